alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: req0 is the core execute path and req1 is the address/auxiliary path.
- Arbitrates with round-robin priority and registers the operands in front of the ALU.
- Waits a programmable settle window, captures the ALU result and branch flag, and returns them with a valid/ready handshake to the requester that was granted.
- Sits between the decode/execute control and the alu instance; exactly one operation is in flight at a time.

Parameters:
WIDTH, 32, operand and result width
SETTLE_CYCLES, 1, cycles operands are held on the ALU before the result is captured; 0 is treated as 1

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
REQ0_VALID  input  1  requester 0 has an operation
REQ0_READY  output  1  arbiter accepts requester 0 this cycle
REQ0_A, REQ0_B  input  WIDTH  requester 0 operands
REQ0_CTRL  input  4  ALU op code (ADD=0 … SLTU=9)
REQ0_BRCOND  input  3  branch condition code
REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_CTRL, REQ1_BRCOND  as requester 0
ALU_A, ALU_B  output  WIDTH  registered operands to ALU
ALU_CTRL  output  4  registered op code to ALU
ALU_BRCOND  output  3  registered branch condition to ALU
ALU_OUT  input  WIDTH  ALU result
ALU_BRFLAG  input  1  ALU branch flag
RSP0_VALID, RSP1_VALID  output  1  response valid for requester 0 / 1
RSP0_READY, RSP1_READY  input  1  requester accepts response
RSP_DATA  output  WIDTH  captured result (shared bus)
RSP_BRFLAG  output  1  captured branch flag
RSP_ILLEGAL  output  1  op code was outside 0..9

Behaviour:
- Reset (async, immediate):
  - state=IDLE, LAST_GNT=1 so requester 0 wins first.
  - ALU_A/ALU_B=0, ALU_CTRL=0, ALU_BRCOND=3'b011 (a code that yields flag 0).
  - RSP_DATA=0, RSP_BRFLAG=0, RSP_ILLEGAL=0, all READY/VALID=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. With one valid, that requester is granted. With both valid, the requester other than LAST_GNT is granted.
  - REQn_READY=1 only for the granted requester and only in IDLE.
  - On VALID&&READY at an edge: latch A, B, CTRL, BRCOND and tag; load counter=max(SETTLE_CYCLES,1); go to EXEC.
  - With no valid: stay in IDLE; ALU_* hold their last values.
- EXEC:
  - ALU_* driven from the operand registers; counter decrements each edge.
  - On the edge where counter==1: RSP_DATA<=ALU_OUT, RSP_BRFLAG<=ALU_BRFLAG, RSP_ILLEGAL<=(CTRL>9); go to RESP.
  - If CTRL>9, RSP_DATA<=0 and RSP_BRFLAG<=0 instead.
- RESP:
  - RSP{tag}_VALID=1 and the other RSP_VALID=0; RSP_* stable until handshake.
  - On RSP{tag}_READY: LAST_GNT<=tag, go to IDLE.
  - No new accept in the handshake cycle; READY rises the next cycle.
- Latency:
  - Accept at edge N; RSP_VALID high after edge N+SETTLE_CYCLES.
  - Peak throughput is one op per SETTLE_CYCLES+2 cycles.
- Requesters must hold VALID and operands until READY; the arbiter samples only at handshake. A VALID dropped before handshake is legal and is simply not served.
- A requester may not raise a new request while its response is pending; the arbiter does not need to detect this.
- RESET mid-EXEC or mid-RESP: the operation and response are dropped and no RSP_VALID is produced.

Optional Feature:
- Macro ALU_LOCK_EN.
- When defined:
  - Adds inputs REQ0_LOCK and REQ1_LOCK, latched with the operation.
  - If the last accepted op had LOCK=1, IDLE grants only that requester; the other requester's READY is held at 0 even when it is valid.
  - The lock releases after the response handshake of an op with LOCK=0.
  - RESET clears the lock.
- When undefined: the LOCK ports are absent and arbitration is pure round-robin.

Test Plan:
- Single op: REQ0 ADD, A=5, B=7, SETTLE=1 → REQ0_READY in IDLE; RSP0_VALID after 1 EXEC cycle with RSP_DATA=12; RSP1_VALID stays 0.
- Contention: both valid every cycle from reset, REQ0 SUB 10-3 and REQ1 XOR F0^0F → responses in order req0(7), req1(FF), req0, req1 …; no requester starves.
- Backpressure: hold RSP1_READY=0 for 5 cycles → RSP_DATA/RSP_BRFLAG stable and both REQ_READY=0 throughout; release → IDLE the next cycle.
- Settle/illegal: SETTLE_CYCLES=3, REQ0 CTRL=4'b1100 → RSP0_VALID exactly 3 edges after accept with RSP_ILLEGAL=1, RSP_DATA=0.
- Reset mid-EXEC: assert RESET in EXEC → all outputs at reset values immediately; no response after release; next grant goes to requester 0.
- (ALU_LOCK_EN) REQ1 LOCK=1 then LOCK=0 while REQ0 continuously valid → both REQ1 ops are served back to back before REQ0 is granted.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, ALU and response signals for alu_share_arbiter.
// Optional macro ALU_LOCK_EN adds the per-requester lock inputs.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_ctrl;
    logic [2:0]       req0_brcond;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_ctrl;
    logic [2:0]       req1_brcond;
`ifdef ALU_LOCK_EN
    logic             req0_lock;
    logic             req1_lock;
`endif
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [2:0]       alu_brcond;
    logic [WIDTH-1:0] alu_out;
    logic             alu_brflag;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic             rsp0_ready;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_brflag;
    logic             rsp_illegal;

    // Arbiter side.
    modport slave (
`ifdef ALU_LOCK_EN
        input  req0_lock, req1_lock,
`endif
        input  req0_valid, req0_a, req0_b, req0_ctrl, req0_brcond,
        input  req1_valid, req1_a, req1_b, req1_ctrl, req1_brcond,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_ctrl, alu_brcond,
        input  alu_out, alu_brflag,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_brflag, rsp_illegal,
        input  rsp0_ready, rsp1_ready
    );

    // Requester / ALU environment side.
    modport master (
`ifdef ALU_LOCK_EN
        output req0_lock, req1_lock,
`endif
        output req0_valid, req0_a, req0_b, req0_ctrl, req0_brcond,
        output req1_valid, req1_a, req1_b, req1_ctrl, req1_brcond,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_ctrl, alu_brcond,
        output alu_out, alu_brflag,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_brflag, rsp_illegal,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered in front of the ALU, held for SETTLE_CYCLES, and the
// captured result is returned to the granted requester with valid/ready.
// Optional macro ALU_LOCK_EN: a locked op keeps the grant on its requester
// until that requester completes an op with lock clear.
module alu_share_arbiter #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic                clk_i,
    input logic                rst_i,
    alu_share_arbiter_if.slave bus
);
    localparam int unsigned    Settle     = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned    CntW       = (Settle < 2) ? 1 : $clog2(Settle + 1);
    localparam logic [CntW-1:0] CntLoad   = CntW'(Settle);
    localparam logic [CntW-1:0] CntLast   = CntW'(1);
    localparam logic [3:0]     MaxCtrl    = 4'd9;
    // Branch condition that makes the ALU report flag 0.
    localparam logic [2:0]     BrcondIdle = 3'b011;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q;
    logic              last_gnt_q;
    logic              tag_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [3:0]        ctrl_q;
    logic [2:0]        brcond_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_brflag_q;
    logic              rsp_illegal_q;

    logic              gnt_valid;
    logic              gnt_idx;
    logic              lock_hold;
    logic              rsp_ready_sel;

`ifdef ALU_LOCK_EN
    logic              lock_q;
    assign lock_hold = lock_q;
`else
    assign lock_hold = 1'b0;
`endif

    // Combinational grant: lock owner first, else round-robin away from last grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (!rst_i && state_q == StIdle) begin
            if (lock_hold) begin
                gnt_idx   = tag_q;
                gnt_valid = tag_q ? bus.req1_valid : bus.req0_valid;
            end else if (bus.req0_valid && bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_idx   = ~last_gnt_q;
            end else if (bus.req0_valid) begin
                gnt_valid = 1'b1;
            end else if (bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
        end
    end

    assign bus.req0_ready  = gnt_valid & ~gnt_idx;
    assign bus.req1_ready  = gnt_valid & gnt_idx;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.alu_brcond  = brcond_q;
    assign bus.rsp0_valid  = (state_q == StResp) & ~tag_q;
    assign bus.rsp1_valid  = (state_q == StResp) & tag_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_brflag  = rsp_brflag_q;
    assign bus.rsp_illegal = rsp_illegal_q;
    assign rsp_ready_sel   = tag_q ? bus.rsp1_ready : bus.rsp0_ready;

    // Sequencer: accept, settle on the ALU, capture, hold until the response handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            last_gnt_q    <= 1'b1;
            tag_q         <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            ctrl_q        <= '0;
            brcond_q      <= BrcondIdle;
            cnt_q         <= '0;
            rsp_data_q    <= '0;
            rsp_brflag_q  <= 1'b0;
            rsp_illegal_q <= 1'b0;
`ifdef ALU_LOCK_EN
            lock_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        tag_q    <= gnt_idx;
                        a_q      <= gnt_idx ? bus.req1_a : bus.req0_a;
                        b_q      <= gnt_idx ? bus.req1_b : bus.req0_b;
                        ctrl_q   <= gnt_idx ? bus.req1_ctrl : bus.req0_ctrl;
                        brcond_q <= gnt_idx ? bus.req1_brcond : bus.req0_brcond;
                        cnt_q    <= CntLoad;
`ifdef ALU_LOCK_EN
                        lock_q   <= gnt_idx ? bus.req1_lock : bus.req0_lock;
`endif
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    cnt_q <= cnt_q - CntLast;
                    if (cnt_q == CntLast) begin
                        if (ctrl_q > MaxCtrl) begin
                            rsp_data_q   <= '0;
                            rsp_brflag_q <= 1'b0;
                        end else begin
                            rsp_data_q   <= bus.alu_out;
                            rsp_brflag_q <= bus.alu_brflag;
                        end
                        rsp_illegal_q <= (ctrl_q > MaxCtrl);
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready_sel) begin
                        last_gnt_q <= tag_q;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. Two instances (settle 1 and 3)
// share stimulus; sel picks which one is driven and observed. A transaction
// model predicts grants, latency and responses from the arbitration rules.
module tb_alu_share_arbiter;
    localparam int unsigned W = 32;

    logic       clk = 1'b0;
    logic [1:0] rst;
    always #5 clk = ~clk;

    logic          sel;
    logic          t_v0, t_v1, t_rr0, t_rr1, t_l0, t_l1;
    logic [W-1:0]  t_a0, t_b0, t_a1, t_b1;
    logic [3:0]    t_c0, t_c1;
    logic [2:0]    t_bc0, t_bc1;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return W'($signed(a) >>> b[4:0]);
            4'd8:    return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd9:    return {{(W-1){1'b0}}, (a < b)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic br_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] c);
        case (c)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return !($signed(a) < $signed(b));
            3'd6:    return a < b;
            3'd7:    return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_dut
        alu_share_arbiter_if #(.WIDTH(W)) bus ();
        alu_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(i == 0 ? 1 : 3)) dut (
            .clk_i (clk),
            .rst_i (rst[i]),
            .bus   (bus)
        );
        assign bus.req0_valid  = t_v0 && (sel == 1'(i));
        assign bus.req1_valid  = t_v1 && (sel == 1'(i));
        assign bus.rsp0_ready  = t_rr0 && (sel == 1'(i));
        assign bus.rsp1_ready  = t_rr1 && (sel == 1'(i));
        assign bus.req0_a      = t_a0;
        assign bus.req0_b      = t_b0;
        assign bus.req0_ctrl   = t_c0;
        assign bus.req0_brcond = t_bc0;
        assign bus.req1_a      = t_a1;
        assign bus.req1_b      = t_b1;
        assign bus.req1_ctrl   = t_c1;
        assign bus.req1_brcond = t_bc1;
`ifdef ALU_LOCK_EN
        assign bus.req0_lock   = t_l0;
        assign bus.req1_lock   = t_l1;
`endif
        assign bus.alu_out     = alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl);
        assign bus.alu_brflag  = br_f(bus.alu_a, bus.alu_b, bus.alu_brcond);
    end

    logic          o_rdy0, o_rdy1, o_rv0, o_rv1, o_brf, o_ill;
    logic [W-1:0]  o_data, o_aa, o_ab;
    logic [3:0]    o_ac;
    logic [2:0]    o_abc;
    assign o_rdy0 = sel ? g_dut[1].bus.req0_ready  : g_dut[0].bus.req0_ready;
    assign o_rdy1 = sel ? g_dut[1].bus.req1_ready  : g_dut[0].bus.req1_ready;
    assign o_rv0  = sel ? g_dut[1].bus.rsp0_valid  : g_dut[0].bus.rsp0_valid;
    assign o_rv1  = sel ? g_dut[1].bus.rsp1_valid  : g_dut[0].bus.rsp1_valid;
    assign o_data = sel ? g_dut[1].bus.rsp_data    : g_dut[0].bus.rsp_data;
    assign o_brf  = sel ? g_dut[1].bus.rsp_brflag  : g_dut[0].bus.rsp_brflag;
    assign o_ill  = sel ? g_dut[1].bus.rsp_illegal : g_dut[0].bus.rsp_illegal;
    assign o_aa   = sel ? g_dut[1].bus.alu_a       : g_dut[0].bus.alu_a;
    assign o_ab   = sel ? g_dut[1].bus.alu_b       : g_dut[0].bus.alu_b;
    assign o_ac   = sel ? g_dut[1].bus.alu_ctrl    : g_dut[0].bus.alu_ctrl;
    assign o_abc  = sel ? g_dut[1].bus.alu_brcond  : g_dut[0].bus.alu_brcond;

    // Reference model state, one slot per instance.
    logic          m_last[2];
    logic          m_lock_on[2];
    logic          m_lock_own[2];
    logic [W-1:0]  m_aa[2], m_ab[2];
    logic [3:0]    m_ac[2];
    logic [2:0]    m_abc[2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int i);
        m_last[i]     = 1'b1;
        m_lock_on[i]  = 1'b0;
        m_lock_own[i] = 1'b0;
        m_aa[i]       = '0;
        m_ab[i]       = '0;
        m_ac[i]       = '0;
        m_abc[i]      = 3'b011;
    endtask

    task automatic check_reset_state(input string tg);
        chk({tg, "_ready"},   {o_rdy1, o_rdy0}, 2'b00);
        chk({tg, "_valid"},   {o_rv1, o_rv0}, 2'b00);
        chk({tg, "_data"},    o_data, 0);
        chk({tg, "_flags"},   {o_brf, o_ill}, 2'b00);
        chk({tg, "_alu_a"},   o_aa, 0);
        chk({tg, "_alu_b"},   o_ab, 0);
        chk({tg, "_alu_ctl"}, {o_ac, o_abc}, {4'd0, 3'b011});
    endtask

    task automatic new_req(input int which);
        logic [W-1:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if (which == 0) begin
            t_v0 = 1'b1; t_a0 = a; t_b0 = b;
            t_c0 = 4'($urandom_range(0, 11)); t_bc0 = 3'($urandom_range(0, 7));
            t_l0 = ($urandom_range(0, 3) == 0);
        end else begin
            t_v1 = 1'b1; t_a1 = a; t_b1 = b;
            t_c1 = 4'($urandom_range(0, 11)); t_bc1 = 3'($urandom_range(0, 7));
            t_l1 = ($urandom_range(0, 3) == 0);
        end
    endtask

    // One arbitration round starting in idle; ends in idle after the response handshake.
    task automatic round(input int bp, output logic won);
        int           i, s;
        logic         g, g_ok, el, eb_f, e_ill;
        logic [W-1:0] ea, eb, ed;
        logic [3:0]   ec;
        logic [2:0]   ebc;
        #1;
        i = int'(sel);
        s = (i == 0) ? 1 : 3;
        if (m_lock_on[i]) begin
            g    = m_lock_own[i];
            g_ok = g ? t_v1 : t_v0;
        end else if (t_v0 && t_v1) begin
            g    = ~m_last[i];
            g_ok = 1'b1;
        end else begin
            g    = !t_v0;
            g_ok = t_v0 || t_v1;
        end
        won = g;
        chk("idle_req0_ready", o_rdy0, g_ok && !g);
        chk("idle_req1_ready", o_rdy1, g_ok && g);
        chk("idle_rsp_valid", {o_rv1, o_rv0}, 2'b00);
        chk("idle_alu_a_hold", o_aa, m_aa[i]);
        chk("idle_alu_ctl_hold", {o_ac, o_abc}, {m_ac[i], m_abc[i]});
        if (!g_ok) begin
            step();
            return;
        end
        ea  = g ? t_a1 : t_a0;
        eb  = g ? t_b1 : t_b0;
        ec  = g ? t_c1 : t_c0;
        ebc = g ? t_bc1 : t_bc0;
`ifdef ALU_LOCK_EN
        el  = g ? t_l1 : t_l0;
`else
        el  = 1'b0;
`endif
        e_ill = (ec > 4'd9);
        ed    = e_ill ? '0 : alu_f(ea, eb, ec);
        eb_f  = e_ill ? 1'b0 : br_f(ea, eb, ebc);
        step();
        if (g) t_v1 = 1'b0; else t_v0 = 1'b0;
        m_aa[i] = ea; m_ab[i] = eb; m_ac[i] = ec; m_abc[i] = ebc;
        for (int k = 1; k <= s; k++) begin
            if (g) begin t_rr1 = 1'b0; t_rr0 = 1'($urandom_range(0, 1)); end
            else begin t_rr0 = 1'b0; t_rr1 = 1'($urandom_range(0, 1)); end
            chk("exec_ready", {o_rdy1, o_rdy0}, 2'b00);
            chk("exec_rsp_valid", {o_rv1, o_rv0}, 2'b00);
            chk("exec_alu_a", o_aa, ea);
            chk("exec_alu_b", o_ab, eb);
            chk("exec_alu_ctl", {o_ac, o_abc}, {ec, ebc});
            step();
        end
        chk("rsp_valid", {o_rv1, o_rv0}, g ? 2'b10 : 2'b01);
        chk("rsp_data", o_data, ed);
        chk("rsp_flags", {o_brf, o_ill}, {eb_f, e_ill});
        repeat (bp) begin
            step();
            chk("bp_valid", {o_rv1, o_rv0}, g ? 2'b10 : 2'b01);
            chk("bp_data", o_data, ed);
            chk("bp_flags", {o_brf, o_ill}, {eb_f, e_ill});
            chk("bp_ready", {o_rdy1, o_rdy0}, 2'b00);
        end
        if (g) t_rr1 = 1'b1; else t_rr0 = 1'b1;
        #1;
        chk("hs_ready", {o_rdy1, o_rdy0}, 2'b00);
        step();
        t_rr0 = 1'b0;
        t_rr1 = 1'b0;
        m_last[i]     = g;
        m_lock_on[i]  = el;
        m_lock_own[i] = g;
    endtask

    initial begin
        logic won;
        sel = 1'b0;
        {t_v0, t_v1, t_rr0, t_rr1, t_l0, t_l1} = '0;
        {t_a0, t_b0, t_a1, t_b1} = '0;
        {t_c0, t_c1, t_bc0, t_bc1} = '0;
        rst = 2'b11;
        t_v0 = 1'b1;
        step();
        step();
        check_reset_state("reset_a");
        sel = 1'b1;
        #1;
        check_reset_state("reset_b");
        t_v0 = 1'b0;
        rst  = 2'b00;
        model_reset(0);
        model_reset(1);
        sel = 1'b0;
        step();

        // Single ADD from requester 0.
        t_v0 = 1'b1; t_a0 = 5; t_b0 = 7; t_c0 = 4'd0; t_bc0 = 3'd0; t_l0 = 1'b0;
        round(0, won);

        // Contention from a fresh reset: alternating grants, no starvation.
        rst[0] = 1'b1;
        #1;
        rst[0] = 1'b0;
        model_reset(0);
        step();
        t_v0 = 1'b1; t_a0 = 10;    t_b0 = 3;    t_c0 = 4'd1; t_bc0 = 3'd1; t_l0 = 1'b0;
        t_v1 = 1'b1; t_a1 = 'hF0;  t_b1 = 'h0F; t_c1 = 4'd4; t_bc1 = 3'd6; t_l1 = 1'b0;
        for (int r = 0; r < 6; r++) begin
            round(0, won);
            if (won) t_v1 = 1'b1; else t_v0 = 1'b1;
        end
        t_v0 = 1'b0;
        t_v1 = 1'b0;
        step();

        // Long backpressure on requester 1.
        new_req(1);
        t_l1 = 1'b0;
        round(5, won);

`ifdef ALU_LOCK_EN
        // Lock: requester 1 keeps the grant across its locked op while requester 0 waits.
        new_req(0);
        t_l0 = 1'b0;
        round(0, won);
        new_req(0);
        t_l0 = 1'b0;
        new_req(1);
        t_l1 = 1'b1;
        round(0, won);
        new_req(1);
        t_l1 = 1'b0;
        round(0, won);
        round(0, won);
`endif

        // Randomised traffic on the settle-1 instance.
        for (int r = 0; r < 30; r++) begin
            if (!t_v0 && $urandom_range(0, 9) < 6) new_req(0);
            if (!t_v1 && $urandom_range(0, 9) < 6) new_req(1);
            round($urandom_range(0, 2), won);
        end
        t_v0 = 1'b0;
        t_v1 = 1'b0;
        step();

        // Settle-3 instance: illegal op code.
        sel = 1'b1;
        step();
        new_req(0);
        t_c0 = 4'b1100;
        t_l0 = 1'b0;
        round(2, won);

        // Reset in the middle of execution drops the op.
        new_req(0);
        new_req(1);
        t_l0 = 1'b0;
        t_l1 = 1'b0;
        round_start_check: begin
            #1;
            chk("rst_pre_ready", {o_rdy1, o_rdy0}, m_last[1] ? 2'b01 : 2'b10);
        end
        step();
        step();
        #2;
        rst[1] = 1'b1;
        #1;
        check_reset_state("rst_mid_exec");
        model_reset(1);
        t_v0 = 1'b0;
        t_v1 = 1'b0;
        #1;
        rst[1] = 1'b0;
        repeat (4) begin
            step();
            chk("rst_no_rsp", {o_rv1, o_rv0}, 2'b00);
        end
        new_req(0);
        new_req(1);
        t_l0 = 1'b0;
        t_l1 = 1'b0;
        round(0, won);

        for (int r = 0; r < 10; r++) begin
            if (!t_v0 && $urandom_range(0, 9) < 6) new_req(0);
            if (!t_v1 && $urandom_range(0, 9) < 6) new_req(1);
            round($urandom_range(0, 2), won);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
